// File: rtl/uart_io_system_if.sv
// uart_io_system_if
// Pin bundle of the I/O controller: host UART pair, the 32-bit parallel
// output register and the SPI master pins.
//   rxd    : host UART serial input (idle high)
//   txd    : host UART serial output (idle high)
//   salida : 32-bit parallel output register
//   sck    : SPI clock (idle low)
//   mosi   : SPI data out
//   miso   : SPI data in
//   fssb   : SPI chip select, active low
// Modports: slave = the controller side, master = the board / test side.
interface uart_io_system_if;
    logic        rxd;
    logic        txd;
    logic [31:0] salida;
    logic        sck;
    logic        mosi;
    logic        miso;
    logic        fssb;

    modport slave (
        input  rxd,
        input  miso,
        output txd,
        output salida,
        output sck,
        output mosi,
        output fssb
    );

    modport master (
        output rxd,
        output miso,
        input  txd,
        input  salida,
        input  sck,
        input  mosi,
        input  fssb
    );
endinterface

// File: rtl/uart_io_system.sv
// uart_io_system
// I/O controller commanded over a host UART (8N1). Commands load a 32-bit
// output register, run one SPI mode-0 byte transfer, exercise a second
// UART (UART B) for link self-test, or read back the output register.
//   Parameters: BAUD_DIV (clocks per UART bit, >= 8), SPI_DIV (clocks per
//               SCK half-period, >= 1).
//   Ports: clk, reset (asynchronous, active high), io (uart_io_system_if
//          slave modport: rxd, txd, salida, sck, mosi, miso, fssb).
//   Build option: define UARTB_LOOPBACK_EN to feed UART B TX straight into
//   UART B RX. Without it UART B RX sees a constant idle line, so command
//   0x03 always ends in the 0xE3 timeout reply.

// ---------------------------------------------------------------------------
// UART receiver: 2-FF synchroniser, false-start rejection, framing check.
// valid pulses for one clock with data when a frame has a good stop bit.
// ---------------------------------------------------------------------------
module uart_io_system_rx #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic       valid,
    output logic [7:0] data
);
    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t        state_reg;
    logic [1:0]       sync_reg;
    logic             prev_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       bit_reg;
    logic [7:0]       shift_reg;
    logic             valid_reg;
    logic [7:0]       data_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= RX_IDLE;
            sync_reg  <= 2'b11;
            prev_reg  <= 1'b1;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else begin
            sync_reg  <= {sync_reg[0], rxd};
            prev_reg  <= sync_reg[1];
            valid_reg <= 1'b0;
            case (state_reg)
                RX_IDLE: begin
                    if (prev_reg && !sync_reg[1]) begin
                        state_reg <= RX_START;
                        cnt_reg   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt_reg == HALF_LAST) begin
                        cnt_reg <= '0;
                        bit_reg <= '0;
                        // Line back high at mid start bit: a glitch, not a frame.
                        state_reg <= sync_reg[1] ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_reg   <= '0;
                        shift_reg <= {sync_reg[1], shift_reg[7:1]};
                        bit_reg   <= bit_reg + 1'b1;
                        if (bit_reg == 3'd7) begin
                            state_reg <= RX_STOP;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= RX_IDLE;
                        if (sync_reg[1]) begin
                            valid_reg <= 1'b1;
                            data_reg  <= shift_reg;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            endcase
        end
    end

    assign valid = valid_reg;
    assign data  = data_reg;
endmodule

// ---------------------------------------------------------------------------
// UART transmitter with a one-byte holding register. A byte waiting in the
// holding register is started straight out of the previous stop bit, so
// consecutive frames have no idle gap.
// ---------------------------------------------------------------------------
module uart_io_system_tx #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    output logic       hold_full,
    output logic       busy,
    output logic       txd
);
    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BAUD_DIV - 1);

    logic             active_reg;
    logic             hold_valid_reg;
    logic [7:0]       hold_reg;
    logic [8:0]       shift_reg;
    logic [3:0]       bit_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             txd_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_reg     <= 1'b0;
            hold_valid_reg <= 1'b0;
            hold_reg       <= '0;
            shift_reg      <= '1;
            bit_reg        <= '0;
            cnt_reg        <= '0;
            txd_reg        <= 1'b1;
        end else begin
            if (!active_reg) begin
                if (hold_valid_reg) begin
                    active_reg     <= 1'b1;
                    hold_valid_reg <= 1'b0;
                    shift_reg      <= {1'b1, hold_reg};
                    bit_reg        <= '0;
                    cnt_reg        <= '0;
                    txd_reg        <= 1'b0;
                end
            end else if (cnt_reg == BIT_LAST) begin
                cnt_reg <= '0;
                if (bit_reg == 4'd9) begin
                    if (hold_valid_reg) begin
                        hold_valid_reg <= 1'b0;
                        shift_reg      <= {1'b1, hold_reg};
                        bit_reg        <= '0;
                        txd_reg        <= 1'b0;
                    end else begin
                        active_reg <= 1'b0;
                    end
                end else begin
                    // shift_reg carries data bits then the stop bit.
                    txd_reg   <= shift_reg[0];
                    shift_reg <= {1'b1, shift_reg[8:1]};
                    bit_reg   <= bit_reg + 1'b1;
                end
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            // Placed last so a load coinciding with a frame start keeps the new byte.
            if (load) begin
                hold_reg       <= data;
                hold_valid_reg <= 1'b1;
            end
        end
    end

    assign hold_full = hold_valid_reg;
    assign busy      = active_reg | hold_valid_reg;
    assign txd       = txd_reg;
endmodule

// ---------------------------------------------------------------------------
// SPI mode-0 master, one byte, MSB first. A transfer is 18 phases of
// SPI_DIV clocks: phases 0-1 lead-in with fssb low and bit 7 on mosi,
// SCK rises at the end of odd phases 1..15 (miso sampled), falls at the
// end of even phases 2..16 (mosi advances), fssb rises after phase 17.
// ---------------------------------------------------------------------------
module uart_io_system_spi #(
    parameter int SPI_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    input  logic       miso,
    output logic       sck,
    output logic       mosi,
    output logic       fssb,
    output logic       done,
    output logic [7:0] rx_data
);
    localparam int CNT_W = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SPI_DIV - 1);

    logic             active_reg;
    logic [4:0]       phase_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [7:0]       tx_reg;
    logic [7:0]       rx_reg;
    logic             sck_reg;
    logic             mosi_reg;
    logic             fssb_reg;
    logic             done_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_reg <= 1'b0;
            phase_reg  <= '0;
            cnt_reg    <= '0;
            tx_reg     <= '0;
            rx_reg     <= '0;
            sck_reg    <= 1'b0;
            mosi_reg   <= 1'b0;
            fssb_reg   <= 1'b1;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (!active_reg) begin
                if (start) begin
                    active_reg <= 1'b1;
                    fssb_reg   <= 1'b0;
                    mosi_reg   <= data[7];
                    tx_reg     <= {data[6:0], 1'b0};
                    phase_reg  <= '0;
                    cnt_reg    <= '0;
                end
            end else if (cnt_reg == DIV_LAST) begin
                cnt_reg   <= '0;
                phase_reg <= phase_reg + 1'b1;
                if (phase_reg == 5'd17) begin
                    fssb_reg   <= 1'b1;
                    active_reg <= 1'b0;
                    done_reg   <= 1'b1;
                end else if (phase_reg[0]) begin
                    sck_reg <= 1'b1;
                    rx_reg  <= {rx_reg[6:0], miso};
                end else if (phase_reg != 5'd0) begin
                    sck_reg <= 1'b0;
                    if (phase_reg != 5'd16) begin
                        mosi_reg <= tx_reg[7];
                        tx_reg   <= {tx_reg[6:0], 1'b0};
                    end
                end
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign sck     = sck_reg;
    assign mosi    = mosi_reg;
    assign fssb    = fssb_reg;
    assign done    = done_reg;
    assign rx_data = rx_reg;
endmodule

// ---------------------------------------------------------------------------
// Top level: command FSM tying the host UART, SPI master and UART B.
// ---------------------------------------------------------------------------
module uart_io_system #(
    parameter int BAUD_DIV = 434,
    parameter int SPI_DIV  = 4
) (
    input  logic               clk,
    input  logic               reset,
    uart_io_system_if.slave    io
);
    localparam int TO_W = $clog2(12 * BAUD_DIV);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(12 * BAUD_DIV - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ARGS, ST_EXEC, ST_REPLY} cmd_state_t;

    logic       host_rx_valid;
    logic [7:0] host_rx_data;
    logic       host_tx_hold_full;
    logic       host_tx_busy;
    logic       host_txd;
    logic       b_rx_valid;
    logic [7:0] b_rx_data;
    logic       b_rx_in;
    logic       b_tx_hold_full;
    logic       b_tx_busy;
    logic       b_txd;
    logic       spi_done;
    logic [7:0] spi_rx_data;
    logic       unused_b;

    cmd_state_t      state_reg;
    logic [7:0]      op_reg;
    logic [2:0]      args_left_reg;
    logic [23:0]     arg_reg;
    logic [31:0]     salida_reg;
    logic [39:0]     reply_buf_reg;
    logic [2:0]      reply_left_reg;
    logic            tx_load_reg;
    logic [7:0]      tx_data_reg;
    logic            spi_start_reg;
    logic            b_load_reg;
    logic            b_sent_reg;
    logic [TO_W-1:0] timer_reg;

    uart_io_system_rx #(.BAUD_DIV(BAUD_DIV)) u_host_rx (
        .clk(clk), .reset(reset), .rxd(io.rxd),
        .valid(host_rx_valid), .data(host_rx_data)
    );

    uart_io_system_tx #(.BAUD_DIV(BAUD_DIV)) u_host_tx (
        .clk(clk), .reset(reset), .load(tx_load_reg), .data(tx_data_reg),
        .hold_full(host_tx_hold_full), .busy(host_tx_busy), .txd(host_txd)
    );

    uart_io_system_tx #(.BAUD_DIV(BAUD_DIV)) u_b_tx (
        .clk(clk), .reset(reset), .load(b_load_reg), .data(arg_reg[7:0]),
        .hold_full(b_tx_hold_full), .busy(b_tx_busy), .txd(b_txd)
    );

`ifdef UARTB_LOOPBACK_EN
    assign b_rx_in = b_txd;
`else
    assign b_rx_in = 1'b1;
`endif
    // UART B's holding flag (and, without loopback, its line) have no consumer.
    assign unused_b = b_tx_hold_full ^ b_txd;

    uart_io_system_rx #(.BAUD_DIV(BAUD_DIV)) u_b_rx (
        .clk(clk), .reset(reset), .rxd(b_rx_in),
        .valid(b_rx_valid), .data(b_rx_data)
    );

    uart_io_system_spi #(.SPI_DIV(SPI_DIV)) u_spi (
        .clk(clk), .reset(reset), .start(spi_start_reg), .data(arg_reg[7:0]),
        .miso(io.miso), .sck(io.sck), .mosi(io.mosi), .fssb(io.fssb),
        .done(spi_done), .rx_data(spi_rx_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            op_reg         <= '0;
            args_left_reg  <= '0;
            arg_reg        <= '0;
            salida_reg     <= '0;
            reply_buf_reg  <= '0;
            reply_left_reg <= '0;
            tx_load_reg    <= 1'b0;
            tx_data_reg    <= '0;
            spi_start_reg  <= 1'b0;
            b_load_reg     <= 1'b0;
            b_sent_reg     <= 1'b0;
            timer_reg      <= '0;
        end else begin
            tx_load_reg   <= 1'b0;
            spi_start_reg <= 1'b0;
            b_load_reg    <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (host_rx_valid) begin
                        op_reg  <= host_rx_data;
                        arg_reg <= '0;
                        case (host_rx_data)
                            8'h01: begin
                                args_left_reg <= 3'd4;
                                state_reg     <= ST_ARGS;
                            end
                            8'h02, 8'h03: begin
                                args_left_reg <= 3'd1;
                                state_reg     <= ST_ARGS;
                            end
                            8'h04: begin
                                reply_buf_reg  <= {8'hA4, salida_reg};
                                reply_left_reg <= 3'd5;
                                state_reg      <= ST_REPLY;
                            end
                            default: begin
                                reply_buf_reg  <= {8'hEE, 32'h0};
                                reply_left_reg <= 3'd1;
                                state_reg      <= ST_REPLY;
                            end
                        endcase
                    end
                end
                ST_ARGS: begin
                    if (host_rx_valid) begin
                        arg_reg       <= {arg_reg[15:0], host_rx_data};
                        args_left_reg <= args_left_reg - 1'b1;
                        if (args_left_reg == 3'd1) begin
                            case (op_reg)
                                8'h01: begin
                                    salida_reg     <= {arg_reg, host_rx_data};
                                    reply_buf_reg  <= {8'hA1, 32'h0};
                                    reply_left_reg <= 3'd1;
                                    state_reg      <= ST_REPLY;
                                end
                                8'h02: begin
                                    spi_start_reg <= 1'b1;
                                    state_reg     <= ST_EXEC;
                                end
                                default: begin
                                    b_load_reg <= 1'b1;
                                    b_sent_reg <= 1'b0;
                                    timer_reg  <= '0;
                                    state_reg  <= ST_EXEC;
                                end
                            endcase
                        end
                    end
                end
                ST_EXEC: begin
                    if (op_reg == 8'h02) begin
                        if (spi_done) begin
                            reply_buf_reg  <= {8'hA2, spi_rx_data, 24'h0};
                            reply_left_reg <= 3'd2;
                            state_reg      <= ST_REPLY;
                        end
                    end else begin
                        // The loopback byte lands mid stop bit, before UART B
                        // TX is idle, so reception is watched throughout.
                        if (b_rx_valid) begin
                            reply_buf_reg  <= {8'hA3, b_rx_data, 24'h0};
                            reply_left_reg <= 3'd2;
                            state_reg      <= ST_REPLY;
                        end else if (b_sent_reg && !b_tx_busy) begin
                            if (timer_reg == TO_LAST) begin
                                reply_buf_reg  <= {8'hE3, 32'h0};
                                reply_left_reg <= 3'd1;
                                state_reg      <= ST_REPLY;
                            end else begin
                                timer_reg <= timer_reg + 1'b1;
                            end
                        end else if (b_tx_busy) begin
                            b_sent_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    // Keep the TX holding register topped up; tx_load_reg
                    // covers the clock before hold_full reflects a load.
                    if (reply_left_reg != 3'd0) begin
                        if (!host_tx_hold_full && !tx_load_reg) begin
                            tx_load_reg    <= 1'b1;
                            tx_data_reg    <= reply_buf_reg[39:32];
                            reply_buf_reg  <= {reply_buf_reg[31:0], 8'h00};
                            reply_left_reg <= reply_left_reg - 1'b1;
                        end
                    end else if (!host_tx_busy && !tx_load_reg) begin
                        state_reg <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign io.txd    = host_txd;
    assign io.salida = salida_reg;
endmodule

// File: tb/tb_uart_io_system.sv
// tb_uart_io_system
// Self-checking bench for uart_io_system: drives host UART frames, decodes
// the txd replies, models an SPI slave and compares against a command-level
// reference model of the controller. Define UARTB_LOOPBACK_EN to match the
// DUT build.
module tb_uart_io_system;
    localparam int BAUD = 16;
    localparam int SDIV = 2;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    uart_io_system_if io();

    uart_io_system #(.BAUD_DIV(BAUD), .SPI_DIV(SDIV)) dut (
        .clk(clk),
        .reset(reset),
        .io(io)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- host-side UART decoder on txd ----------------
    logic [7:0] mon_q[$];
    int         mon_t_q[$];

    initial begin : txd_monitor
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (io.txd === 1'b0 && reset === 1'b0) begin
                mon_t_q.push_back(cyc);
                repeat (BAUD / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BAUD) @(negedge clk);
                    b[i] = io.txd;
                end
                repeat (BAUD) @(negedge clk);
                mon_q.push_back(b);
            end
        end
    end

    // ---------------- SPI slave model ----------------
    logic [7:0] spi_resp = 8'h00;
    logic [7:0] spi_sh   = 8'h00;
    logic [7:0] mosi_cap = 8'h00;
    int         rise_cnt = 0;
    int         fssb_len = 0;
    logic       prev_fssb = 1'b1;
    logic       prev_sck  = 1'b0;

    always @(negedge clk) begin
        if (prev_fssb === 1'b1 && io.fssb === 1'b0) spi_sh = spi_resp;
        else if (prev_sck === 1'b1 && io.sck === 1'b0) spi_sh = {spi_sh[6:0], 1'b0};
        if (prev_sck === 1'b0 && io.sck === 1'b1) begin
            mosi_cap = {mosi_cap[6:0], io.mosi};
            rise_cnt++;
        end
        if (io.fssb === 1'b0) fssb_len++;
        prev_fssb = io.fssb;
        prev_sck  = io.sck;
    end
    assign io.miso = spi_sh[7];

    // ---------------- host UART driver ----------------
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        io.rxd = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            io.rxd = b[i];
            repeat (BAUD) @(negedge clk);
        end
        io.rxd = stop_bit;
        repeat (BAUD) @(negedge clk);
        io.rxd = 1'b1;
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int k = 0;
        while (mon_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (12 * BAUD) @(negedge clk);
    endtask

    // ---------------- reference model + one command ----------------
    logic [31:0] salida_m = 32'h0;

    task automatic run_cmd(input logic [7:0] op, input logic [31:0] argv, input logic [7:0] miso_byte);
        logic [7:0] exp_q[$];
        int rise0;
        int len0;
        exp_q.delete();
        case (op)
            8'h01: begin salida_m = argv; exp_q.push_back(8'hA1); end
            8'h02: begin exp_q.push_back(8'hA2); exp_q.push_back(miso_byte); end
`ifdef UARTB_LOOPBACK_EN
            8'h03: begin exp_q.push_back(8'hA3); exp_q.push_back(argv[7:0]); end
`else
            8'h03: exp_q.push_back(8'hE3);
`endif
            8'h04: begin
                exp_q.push_back(8'hA4);
                for (int i = 3; i >= 0; i--) exp_q.push_back(salida_m[8*i +: 8]);
            end
            default: exp_q.push_back(8'hEE);
        endcase
        spi_resp = miso_byte;
        rise0 = rise_cnt;
        len0  = fssb_len;
        mon_q.delete();
        mon_t_q.delete();
        repeat (BAUD) @(negedge clk);
        send_byte(op, 1'b1);
        if (op == 8'h01) begin
            for (int i = 3; i >= 0; i--) send_byte(argv[8*i +: 8], 1'b1);
        end else if (op == 8'h02 || op == 8'h03) begin
            send_byte(argv[7:0], 1'b1);
        end
        wait_bytes(exp_q.size(), 60 * BAUD + 10 * BAUD * exp_q.size());
        check_value($sformatf("reply_len_%02h", op), mon_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < mon_q.size())
                check_value($sformatf("reply_%02h_byte%0d", op, i), mon_q[i], exp_q[i]);
        end
        for (int i = 1; i < mon_t_q.size(); i++)
            check_value($sformatf("reply_%02h_gap%0d", op, i), mon_t_q[i] - mon_t_q[i-1], 10 * BAUD);
        check_value($sformatf("salida_after_%02h", op), io.salida, salida_m);
        if (op == 8'h02) begin
            check_value("spi_mosi", mosi_cap, argv[7:0]);
            check_value("spi_rises", rise_cnt - rise0, 8);
            check_value("spi_fssb_low", fssb_len - len0, 18 * SDIV);
        end else begin
            check_value($sformatf("no_spi_%02h", op), rise_cnt - rise0, 0);
        end
        $display("cmd %02h arg %08h : %0d reply bytes, first %02h", op, argv, mon_q.size(),
                 (mon_q.size() > 0) ? mon_q[0] : 8'h00);
    endtask

    initial begin : watchdog
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int lows;
        int k;
        logic [7:0]  op;
        logic [31:0] argv;
        io.rxd = 1'b1;
        reset  = 1'b1;
        repeat (5) @(negedge clk);
        check_value("rst_txd", io.txd, 1'b1);
        check_value("rst_salida", io.salida, 32'h0);
        check_value("rst_fssb", io.fssb, 1'b1);
        check_value("rst_sck", io.sck, 1'b0);
        check_value("rst_mosi", io.mosi, 1'b0);
        reset = 1'b0;

        lows = 0;
        repeat (20 * BAUD) begin
            @(negedge clk);
            if (io.txd !== 1'b1) lows++;
        end
        check_value("idle_txd_quiet", lows, 0);

        run_cmd(8'h01, 32'hDEADBEEF, 8'h00);
        run_cmd(8'h04, 32'h0, 8'h00);
        run_cmd(8'h02, 32'h000000A5, 8'h3C);
        run_cmd(8'h03, 32'h0000005A, 8'h00);
        run_cmd(8'h7F, 32'h0, 8'h00);

        // Frame with a zero stop bit is discarded: no reply at all.
        mon_q.delete();
        send_byte(8'h04, 1'b0);
        repeat (30 * BAUD) @(negedge clk);
        check_value("bad_stop_no_reply", mon_q.size(), 0);
        $display("cmd 04 with stop bit 0 : %0d reply bytes", mon_q.size());

        for (int n = 0; n < 14; n++) begin
            case ($urandom_range(0, 4))
                0: op = 8'h01;
                1: op = 8'h02;
                2: op = 8'h03;
                3: op = 8'h04;
                default: op = 8'($urandom_range(5, 255));
            endcase
            argv = $urandom;
            run_cmd(op, argv, 8'($urandom));
        end

        // Reset in the middle of the 0xA1 reply.
        argv = $urandom;
        mon_q.delete();
        send_byte(8'h01, 1'b1);
        for (int i = 3; i >= 0; i--) send_byte(argv[8*i +: 8], 1'b1);
        k = 0;
        while (io.txd !== 1'b0 && k < 40 * BAUD) begin
            @(negedge clk);
            k++;
        end
        check_value("a1_start_seen", io.txd, 1'b0);
        check_value("salida_before_rst", io.salida, argv);
        repeat (3 * BAUD) @(negedge clk);
        check_value("a1_bit2_low", io.txd, 1'b0);
        #2 reset = 1'b1;
        #1;
        check_value("async_rst_txd", io.txd, 1'b1);
        check_value("async_rst_salida", io.salida, 32'h0);
        check_value("async_rst_fssb", io.fssb, 1'b1);
        $display("reset during A1 reply : txd %0b salida %08h", io.txd, io.salida);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        salida_m = 32'h0;
        repeat (12 * BAUD) @(negedge clk);
        mon_q.delete();
        run_cmd(8'h04, 32'h0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
